// File: rtl/rs_preio_bridge.sv
// Word-wide PREIO bridge: SoC <-> fabric through two first-word-fall-through FIFOs
// with valid/ready handshakes, A2F overflow capture and F2A occupancy reporting.
module rs_preio_bridge #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned A2F_DEPTH = 4,
  parameter int unsigned F2A_DEPTH = 4
) (
  input  logic                         pad_clk,
  input  logic                         pad_reset_n,
  input  logic [DATA_W-1:0]            gfpga_pad_RS_PREIO_A2F,
  input  logic                         gfpga_pad_RS_PREIO_A2F_VALID,
  output logic [DATA_W-1:0]            pad_inpad,
  output logic                         pad_inpad_valid,
  input  logic                         pad_inpad_ready,
  input  logic [DATA_W-1:0]            pad_outpad,
  input  logic                         pad_outpad_valid,
  output logic                         pad_outpad_ready,
  output logic [DATA_W-1:0]            gfpga_pad_RS_PREIO_F2A,
  output logic                         gfpga_pad_RS_PREIO_F2A_VALID,
  input  logic                         gfpga_pad_RS_PREIO_F2A_READY,
  output logic                         a2f_overflow,
  input  logic                         a2f_overflow_clr,
  output logic [$clog2(F2A_DEPTH):0]   f2a_level
);

  localparam int unsigned A2fPtrW = $clog2(A2F_DEPTH);
  localparam int unsigned A2fCntW = A2fPtrW + 1;
  localparam int unsigned F2aPtrW = $clog2(F2A_DEPTH);
  localparam int unsigned F2aCntW = F2aPtrW + 1;

  // ---------------------------------------------------------------------------
  // SoC -> fabric FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]  a2f_mem [A2F_DEPTH];
  logic [A2fPtrW-1:0] a2f_wptr_q, a2f_wptr_d;
  logic [A2fPtrW-1:0] a2f_rptr_q, a2f_rptr_d;
  logic [A2fCntW-1:0] a2f_count_q, a2f_count_d;
  logic               a2f_ovf_q, a2f_ovf_d;
  logic               a2f_valid, a2f_full;
  logic               a2f_push, a2f_pop, a2f_drop;

  assign a2f_valid = (a2f_count_q != '0);
  assign a2f_full  = (a2f_count_q == A2fCntW'(A2F_DEPTH));
  assign a2f_pop   = a2f_valid && pad_inpad_ready;
  // A strobe into a full FIFO still lands if the head leaves on the same edge.
  assign a2f_push  = gfpga_pad_RS_PREIO_A2F_VALID && (!a2f_full || a2f_pop);
  assign a2f_drop  = gfpga_pad_RS_PREIO_A2F_VALID && a2f_full && !a2f_pop;

  always_comb begin
    a2f_wptr_d  = a2f_wptr_q;
    a2f_rptr_d  = a2f_rptr_q;
    a2f_count_d = a2f_count_q;
    a2f_ovf_d   = a2f_ovf_q;
    if (a2f_push) begin
      a2f_wptr_d = a2f_wptr_q + A2fPtrW'(1);
    end
    if (a2f_pop) begin
      a2f_rptr_d = a2f_rptr_q + A2fPtrW'(1);
    end
    if (a2f_push && !a2f_pop) begin
      a2f_count_d = a2f_count_q + A2fCntW'(1);
    end else if (!a2f_push && a2f_pop) begin
      a2f_count_d = a2f_count_q - A2fCntW'(1);
    end
    if (a2f_drop) begin
      a2f_ovf_d = 1'b1;
    end else if (a2f_overflow_clr) begin
      a2f_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge pad_clk or negedge pad_reset_n) begin
    if (!pad_reset_n) begin
      a2f_wptr_q  <= '0;
      a2f_rptr_q  <= '0;
      a2f_count_q <= '0;
      a2f_ovf_q   <= 1'b0;
    end else begin
      a2f_wptr_q  <= a2f_wptr_d;
      a2f_rptr_q  <= a2f_rptr_d;
      a2f_count_q <= a2f_count_d;
      a2f_ovf_q   <= a2f_ovf_d;
    end
  end

  always_ff @(posedge pad_clk) begin
    if (a2f_push) begin
      a2f_mem[a2f_wptr_q] <= gfpga_pad_RS_PREIO_A2F;
    end
  end

  // Head is gated by valid so the data output reads zero while empty or in reset.
  assign pad_inpad       = a2f_valid ? a2f_mem[a2f_rptr_q] : '0;
  assign pad_inpad_valid = a2f_valid;
  assign a2f_overflow    = a2f_ovf_q;

  // ---------------------------------------------------------------------------
  // Fabric -> SoC FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]  f2a_mem [F2A_DEPTH];
  logic [F2aPtrW-1:0] f2a_wptr_q, f2a_wptr_d;
  logic [F2aPtrW-1:0] f2a_rptr_q, f2a_rptr_d;
  logic [F2aCntW-1:0] f2a_count_q, f2a_count_d;
  logic               f2a_valid, f2a_ready;
  logic               f2a_push, f2a_pop;

  assign f2a_valid = (f2a_count_q != '0);
  // Ready depends only on the registered count, never on the SoC-side ready.
  assign f2a_ready = (f2a_count_q != F2aCntW'(F2A_DEPTH));
  assign f2a_push  = pad_outpad_valid && f2a_ready;
  assign f2a_pop   = f2a_valid && gfpga_pad_RS_PREIO_F2A_READY;

  always_comb begin
    f2a_wptr_d  = f2a_wptr_q;
    f2a_rptr_d  = f2a_rptr_q;
    f2a_count_d = f2a_count_q;
    if (f2a_push) begin
      f2a_wptr_d = f2a_wptr_q + F2aPtrW'(1);
    end
    if (f2a_pop) begin
      f2a_rptr_d = f2a_rptr_q + F2aPtrW'(1);
    end
    if (f2a_push && !f2a_pop) begin
      f2a_count_d = f2a_count_q + F2aCntW'(1);
    end else if (!f2a_push && f2a_pop) begin
      f2a_count_d = f2a_count_q - F2aCntW'(1);
    end
  end

  always_ff @(posedge pad_clk or negedge pad_reset_n) begin
    if (!pad_reset_n) begin
      f2a_wptr_q  <= '0;
      f2a_rptr_q  <= '0;
      f2a_count_q <= '0;
    end else begin
      f2a_wptr_q  <= f2a_wptr_d;
      f2a_rptr_q  <= f2a_rptr_d;
      f2a_count_q <= f2a_count_d;
    end
  end

  always_ff @(posedge pad_clk) begin
    if (f2a_push) begin
      f2a_mem[f2a_wptr_q] <= pad_outpad;
    end
  end

  assign gfpga_pad_RS_PREIO_F2A       = f2a_valid ? f2a_mem[f2a_rptr_q] : '0;
  assign gfpga_pad_RS_PREIO_F2A_VALID = f2a_valid;
  assign pad_outpad_ready             = f2a_ready;
  assign f2a_level                    = f2a_count_q;

endmodule

// File: tb/tb_rs_preio_bridge.sv
// Self-checking bench for rs_preio_bridge: queue-based reference model, a vector
// table for the A2F overflow/full-pop cases, and hand sequences for the rest.
module tb_rs_preio_bridge;

  localparam int unsigned DW = 8;
  localparam int unsigned AD = 4;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] a2f_data;
  logic          a2f_strobe;
  logic [DW-1:0] inpad;
  logic          inpad_valid;
  logic          inpad_ready;
  logic [DW-1:0] outpad;
  logic          outpad_valid;
  logic          outpad_ready;
  logic [DW-1:0] f2a_data;
  logic          f2a_valid;
  logic          f2a_ready;
  logic          ovf;
  logic          ovf_clr;
  logic [2:0]    level;

  rs_preio_bridge #(.DATA_W(DW), .A2F_DEPTH(AD), .F2A_DEPTH(FD)) dut (
    .pad_clk                      (clk),
    .pad_reset_n                  (rst_n),
    .gfpga_pad_RS_PREIO_A2F       (a2f_data),
    .gfpga_pad_RS_PREIO_A2F_VALID (a2f_strobe),
    .pad_inpad                    (inpad),
    .pad_inpad_valid              (inpad_valid),
    .pad_inpad_ready              (inpad_ready),
    .pad_outpad                   (outpad),
    .pad_outpad_valid             (outpad_valid),
    .pad_outpad_ready             (outpad_ready),
    .gfpga_pad_RS_PREIO_F2A       (f2a_data),
    .gfpga_pad_RS_PREIO_F2A_VALID (f2a_valid),
    .gfpga_pad_RS_PREIO_F2A_READY (f2a_ready),
    .a2f_overflow                 (ovf),
    .a2f_overflow_clr             (ovf_clr),
    .f2a_level                    (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues holding what each FIFO should contain.
  logic [DW-1:0] m_a2f[$];
  logic [DW-1:0] m_f2a[$];
  logic          m_ovf;

  // Words observed leaving each FIFO, and whether the fabric word was taken.
  logic [DW-1:0] a2f_rx[$];
  logic [DW-1:0] f2a_rx[$];
  logic          last_f_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a2f.delete();
    m_f2a.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit a_pop, a_drop, f_pop, f_push;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a_pop  = (m_a2f.size() > 0) && inpad_ready;
    a_drop = a2f_strobe && (m_a2f.size() == AD) && !a_pop;
    if (a_pop) void'(m_a2f.pop_front());
    if (a2f_strobe && !a_drop) m_a2f.push_back(a2f_data);
    if (a_drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    f_push = outpad_valid && (m_f2a.size() < FD);
    f_pop  = (m_f2a.size() > 0) && f2a_ready;
    if (f_pop) void'(m_f2a.pop_front());
    if (f_push) m_f2a.push_back(outpad);
  endtask

  task automatic check_model();
    chk("inpad_valid", 32'(inpad_valid), 32'(m_a2f.size() > 0));
    chk("inpad", 32'(inpad), (m_a2f.size() > 0) ? 32'(m_a2f[0]) : 32'd0);
    chk("f2a_valid", 32'(f2a_valid), 32'(m_f2a.size() > 0));
    chk("f2a_data", 32'(f2a_data), (m_f2a.size() > 0) ? 32'(m_f2a[0]) : 32'd0);
    chk("outpad_ready", 32'(outpad_ready), 32'(m_f2a.size() < FD));
    chk("f2a_level", 32'(level), 32'(m_f2a.size()));
    chk("a2f_overflow", 32'(ovf), 32'(m_ovf));
  endtask

  // One clock: record handshakes, let the edge happen, update model, compare.
  task automatic tick();
    if (inpad_valid && inpad_ready) a2f_rx.push_back(inpad);
    if (f2a_valid && f2a_ready) f2a_rx.push_back(f2a_data);
    last_f_acc = outpad_valid && outpad_ready;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    a2f_strobe   = 1'b0;
    a2f_data     = '0;
    inpad_ready  = 1'b0;
    outpad_valid = 1'b0;
    outpad       = '0;
    f2a_ready    = 1'b0;
    ovf_clr      = 1'b0;
  endtask

  typedef struct {
    logic          strobe;
    logic [DW-1:0] data;
    logic          rdy;
    logic          clr;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic [DW-1:0] d, logic r, logic c,
                              logic ev, logic [DW-1:0] ed, logic eo);
    vec_t v;
    v.strobe = s; v.data = d; v.rdy = r; v.clr = c;
    v.exp_valid = ev; v.exp_data = ed; v.exp_ovf = eo;
    return v;
  endfunction

  initial begin
    int f_idx;
    int a_tx;
    int f_tx;
    int cyc;

    model_reset();
    idle_inputs();
    rst_n = 1'b0;

    // Reset held with random inputs: outputs must stay at reset values.
    for (int i = 0; i < 4; i++) begin
      a2f_strobe   = 1'($urandom_range(0, 1));
      a2f_data     = 8'($urandom);
      inpad_ready  = 1'($urandom_range(0, 1));
      outpad_valid = 1'($urandom_range(0, 1));
      outpad       = 8'($urandom);
      f2a_ready    = 1'($urandom_range(0, 1));
      tick();
    end
    chk("reset_outpad_ready", 32'(outpad_ready), 32'd1);
    chk("reset_level", 32'(level), 32'd0);

    idle_inputs();
    rst_n = 1'b1;
    tick();

    a2f_strobe = 1'b1;
    a2f_data   = 8'hA5;
    tick();
    chk("first_word_data", 32'(inpad), 32'hA5);
    chk("first_word_valid", 32'(inpad_valid), 32'd1);
    idle_inputs();
    inpad_ready = 1'b1;
    tick();
    idle_inputs();
    tick();

    // Overflow, full-with-pop, and clear-vs-drop as a vector table.
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 8'h01, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 1, 8'h01, 0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 1, 8'h01, 0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 1, 8'h01, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 1, 8'h01, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h02, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h03, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h04, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h10, 0, 0, 1, 8'h10, 0));
    vecs.push_back(mk(1, 8'h11, 0, 0, 1, 8'h10, 0));
    vecs.push_back(mk(1, 8'h12, 0, 0, 1, 8'h10, 0));
    vecs.push_back(mk(1, 8'h13, 0, 0, 1, 8'h10, 0));
    vecs.push_back(mk(1, 8'h14, 1, 0, 1, 8'h11, 0));
    vecs.push_back(mk(1, 8'h15, 0, 1, 1, 8'h11, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 8'h11, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h12, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h13, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h14, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0));
    foreach (vecs[i]) begin
      a2f_strobe  = vecs[i].strobe;
      a2f_data    = vecs[i].data;
      inpad_ready = vecs[i].rdy;
      ovf_clr     = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(inpad_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i), 32'(inpad), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
    end
    idle_inputs();

    // F2A backpressure: fabric holds each word until accepted.
    f2a_rx.delete();
    f_idx        = 0;
    outpad_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      outpad = 8'(8'hC0 + f_idx);
      tick();
      if (last_f_acc) f_idx++;
    end
    chk("bp_accepts", 32'(f_idx), 32'd4);
    chk("bp_ready_low", 32'(outpad_ready), 32'd0);
    chk("bp_level_full", 32'(level), 32'd4);
    outpad    = 8'hC4;
    f2a_ready = 1'b1;
    tick();
    if (last_f_acc) f_idx++;
    f2a_ready = 1'b0;
    chk("bp_no_push_on_pop", 32'(f_idx), 32'd4);
    chk("bp_ready_back", 32'(outpad_ready), 32'd1);
    chk("bp_level_3", 32'(level), 32'd3);
    tick();
    if (last_f_acc) f_idx++;
    chk("bp_c4_taken", 32'(f_idx), 32'd5);
    chk("bp_level_4", 32'(level), 32'd4);
    f2a_ready = 1'b1;
    cyc = 0;
    while ((f2a_rx.size() < 6) && (cyc < 40)) begin
      outpad_valid = (f_idx < 6);
      outpad       = 8'(8'hC0 + f_idx);
      tick();
      if (last_f_acc) f_idx++;
      cyc++;
    end
    chk("bp_rx_count", 32'(f2a_rx.size()), 32'd6);
    foreach (f2a_rx[i]) chk($sformatf("bp_rx%0d", i), 32'(f2a_rx[i]), 32'(8'hC0 + i));
    idle_inputs();
    tick();

    // Random streaming of 40 words each way, exercising pointer wrap.
    a2f_rx.delete();
    f2a_rx.delete();
    a_tx = 0;
    f_tx = 0;
    cyc  = 0;
    while (((a2f_rx.size() < 40) || (f2a_rx.size() < 40)) && (cyc < 2000)) begin
      a2f_strobe   = (a_tx < 40) && (m_a2f.size() < AD) && ($urandom_range(0, 1) == 1);
      a2f_data     = 8'(a_tx);
      inpad_ready  = 1'($urandom_range(0, 1));
      outpad_valid = (f_tx < 40) && ($urandom_range(0, 2) != 0);
      outpad       = 8'(8'h80 + f_tx);
      f2a_ready    = 1'($urandom_range(0, 1));
      tick();
      if (a2f_strobe) a_tx++;
      if (last_f_acc) f_tx++;
      if (level > 3'd4) chk("rand_level_bound", 32'(level), 32'd4);
      cyc++;
    end
    chk("rand_a2f_count", 32'(a2f_rx.size()), 32'd40);
    chk("rand_f2a_count", 32'(f2a_rx.size()), 32'd40);
    foreach (a2f_rx[i]) chk($sformatf("rand_a2f%0d", i), 32'(a2f_rx[i]), 32'(i));
    foreach (f2a_rx[i]) chk($sformatf("rand_f2a%0d", i), 32'(f2a_rx[i]), 32'(8'h80 + i));
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    // Mid-operation reset with three words in each FIFO.
    for (int i = 0; i < 3; i++) begin
      a2f_strobe   = 1'b1;
      a2f_data     = 8'(8'h50 + i);
      outpad_valid = 1'b1;
      outpad       = 8'(8'h60 + i);
      tick();
    end
    idle_inputs();
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #2;
    chk("rst_inpad_valid", 32'(inpad_valid), 32'd0);
    chk("rst_f2a_valid", 32'(f2a_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_outpad_ready", 32'(outpad_ready), 32'd1);
    chk("rst_inpad", 32'(inpad), 32'd0);
    rst_n = 1'b1;
    model_reset();
    inpad_ready = 1'b1;
    f2a_ready   = 1'b1;
    a2f_rx.delete();
    f2a_rx.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_no_stale_a2f", 32'(a2f_rx.size()), 32'd0);
    chk("post_rst_no_stale_f2a", 32'(f2a_rx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
